// File: rtl/cpu_controller.sv
// cpu_controller: instruction register, decoder and multi-cycle control FSM for the 16-bit CPU
module cpu_controller #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [2:0]        readnum,
  output logic [2:0]        writenum,
  output logic              write,
  output logic [1:0]        vsel,
  output logic              loada,
  output logic              loadb,
  output logic              loadc,
  output logic              loads,
  output logic              asel,
  output logic              bsel,
  output logic [1:0]        shift,
  output logic [1:0]        ALUop,
  output logic [DATA_W-1:0] sximm8,
  output logic [DATA_W-1:0] sximm5,
  output logic [1:0]        mem_cmd,
  output logic              addr_sel,
  output logic              load_pc,
  output logic              reset_pc,
  output logic              load_addr,
  output logic              halt
);
  typedef enum logic [4:0] {
    S_RST, S_IF1, S_IF2, S_UPD, S_DEC, S_WIMM, S_GETA, S_GETB, S_ALU,
    S_WREG, S_ADDR, S_LADDR, S_MEMRD, S_LDRWB, S_STRB, S_STRC, S_MEMWR, S_HALT
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] ir_q, ir_d;

  logic [2:0] opcode, rn, rd, rm;
  logic [1:0] op;
  logic       is_cmp, is_asel;

  assign opcode  = ir_q[15:13];
  assign op      = ir_q[12:11];
  assign rn      = ir_q[10:8];
  assign rd      = ir_q[7:5];
  assign rm      = ir_q[2:0];
  assign is_cmp  = {opcode, op} == 5'b10101;
  assign is_asel = {opcode, op} == 5'b11000 || {opcode, op} == 5'b10111;
  assign sximm8  = {{(DATA_W-8){ir_q[7]}}, ir_q[7:0]};
  assign sximm5  = {{(DATA_W-5){ir_q[4]}}, ir_q[4:0]};

  // Next state and instruction capture; MOV reg and MVN skip GET_A since A is forced to 0
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    case (state_q)
      S_RST:   state_d = S_IF1;
      S_IF1:   state_d = S_IF2;
      S_IF2:   begin state_d = S_UPD; ir_d = mem_rdata; end
      S_UPD:   state_d = S_DEC;
      S_DEC:
        casez ({opcode, op})
          5'b11010:          state_d = S_WIMM;
          5'b11000, 5'b10111: state_d = S_GETB;
          5'b101??:          state_d = S_GETA;
          5'b01100, 5'b10000: state_d = S_GETA;
          default:           state_d = S_HALT;
        endcase
      S_WIMM, S_WREG, S_LDRWB, S_MEMWR: state_d = S_IF1;
      S_GETA:  state_d = opcode == 3'b101 ? S_GETB : S_ADDR;
      S_GETB:  state_d = S_ALU;
      S_ALU:   state_d = is_cmp ? S_IF1 : S_WREG;
      S_ADDR:  state_d = S_LADDR;
      S_LADDR: state_d = opcode == 3'b011 ? S_MEMRD : S_STRB;
      S_MEMRD: state_d = S_LDRWB;
      S_STRB:  state_d = S_STRC;
      S_STRC:  state_d = S_MEMWR;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RST;
    endcase
  end

  // State and IR registers, cleared asynchronously by reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_RST;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // Moore control outputs decoded from state and IR fields
  always_comb begin
    readnum   = '0;
    writenum  = '0;
    write     = 1'b0;
    vsel      = 2'b00;
    loada     = 1'b0;
    loadb     = 1'b0;
    loadc     = 1'b0;
    loads     = 1'b0;
    asel      = 1'b0;
    bsel      = 1'b0;
    shift     = ir_q[4:3];
    ALUop     = ir_q[12:11];
    mem_cmd   = 2'b00;
    addr_sel  = 1'b0;
    load_pc   = 1'b0;
    reset_pc  = 1'b0;
    load_addr = 1'b0;
    halt      = 1'b0;
    case (state_q)
      S_RST:   begin reset_pc = 1'b1; load_pc = 1'b1; end
      S_IF1, S_IF2: begin addr_sel = 1'b1; mem_cmd = 2'b01; end
      S_UPD:   load_pc = 1'b1;
      S_WIMM:  begin writenum = rn; vsel = 2'b10; write = 1'b1; end
      S_GETA:  begin readnum = rn; loada = 1'b1; end
      S_GETB:  begin readnum = rm; loadb = 1'b1; end
      S_ALU:   begin loads = is_cmp; loadc = !is_cmp; asel = is_asel; end
      S_WREG:  begin writenum = rd; write = 1'b1; end
      S_ADDR:  begin bsel = 1'b1; shift = 2'b00; ALUop = 2'b00; loadc = 1'b1; end
      S_LADDR: load_addr = 1'b1;
      S_MEMRD: mem_cmd = 2'b01;
      S_LDRWB: begin mem_cmd = 2'b01; vsel = 2'b11; writenum = rd; write = 1'b1; end
      S_STRB:  begin readnum = rd; loadb = 1'b1; end
      S_STRC:  begin asel = 1'b1; shift = 2'b00; ALUop = 2'b00; loadc = 1'b1; end
      S_MEMWR: mem_cmd = 2'b10;
      S_HALT:  halt = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_cpu_controller.sv
// tb_cpu_controller: table-driven instruction sequences plus reset and halt corner cases
module tb_cpu_controller;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic [2:0]  readnum, writenum;
  logic        write, loada, loadb, loadc, loads, asel, bsel;
  logic [1:0]  vsel, shift, ALUop, mem_cmd;
  logic [15:0] sximm8, sximm5;
  logic        addr_sel, load_pc, reset_pc, load_addr, halt;

  cpu_controller #(.DATA_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .mem_rdata(mem_rdata),
    .readnum(readnum), .writenum(writenum), .write(write), .vsel(vsel),
    .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
    .asel(asel), .bsel(bsel), .shift(shift), .ALUop(ALUop),
    .sximm8(sximm8), .sximm5(sximm5), .mem_cmd(mem_cmd), .addr_sel(addr_sel),
    .load_pc(load_pc), .reset_pc(reset_pc), .load_addr(load_addr), .halt(halt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] readnum, writenum;
    logic       write;
    logic [1:0] vsel;
    logic       loada, loadb, loadc, loads, asel, bsel;
    logic [1:0] shift, aluop, mem_cmd;
    logic       addr_sel, load_pc, reset_pc, load_addr, halt;
  } ctrl_t;

  typedef struct {
    logic [15:0] instr;
    int          ncyc;
    int          kidx;
    ctrl_t       key;
    logic [15:0] sx8, sx5;
  } vec_t;

  vec_t tbl[$];
  int   n_chk = 0, n_pass = 0;
  logic arm = 1'b0, saw_write = 1'b0;

  always @(write) if (arm && write) saw_write = 1'b1;

  function automatic ctrl_t base(input logic [15:0] ir);
    ctrl_t c = '0;
    c.shift = ir[4:3];
    c.aluop = ir[12:11];
    return c;
  endfunction

  function automatic ctrl_t if1_c(input logic [15:0] ir);
    ctrl_t c = base(ir);
    c.addr_sel = 1'b1;
    c.mem_cmd  = 2'b01;
    return c;
  endfunction

  function automatic ctrl_t rst_c();
    ctrl_t c = base(16'h0000);
    c.reset_pc = 1'b1;
    c.load_pc  = 1'b1;
    return c;
  endfunction

  function automatic ctrl_t cur();
    return '{readnum, writenum, write, vsel, loada, loadb, loadc, loads, asel, bsel,
             shift, ALUop, mem_cmd, addr_sel, load_pc, reset_pc, load_addr, halt};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic chk_ne(input string nm, input logic [31:0] act, input logic [31:0] bad);
    n_chk++;
    if (act !== bad) n_pass++;
    else $display("FAIL %s: got %h which must differ from %h", nm, act, bad);
  endtask

  task automatic add(input logic [15:0] instr, input int ncyc, input int kidx, input ctrl_t key,
                     input logic [15:0] sx8, input logic [15:0] sx5);
    vec_t v;
    v.instr = instr; v.ncyc = ncyc; v.kidx = kidx; v.key = key; v.sx8 = sx8; v.sx5 = sx5;
    tbl.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    ctrl_t k;
    k = base(16'hD105); k.writenum = 3'd1; k.vsel = 2'b10; k.write = 1'b1;
    add(16'hD105, 5, 4, k, 16'h0005, 16'h0005);
    k = base(16'hD0FF); k.writenum = 3'd0; k.vsel = 2'b10; k.write = 1'b1;
    add(16'hD0FF, 5, 4, k, 16'hFFFF, 16'hFFFF);
    k = base(16'hA0A1); k.readnum = 3'd0; k.loada = 1'b1;
    add(16'hA0A1, 8, 4, k, 16'hFFA1, 16'h0001);
    k = base(16'hA0A1); k.readnum = 3'd1; k.loadb = 1'b1;
    add(16'hA0A1, 8, 5, k, 16'hFFA1, 16'h0001);
    k = base(16'hA0A1); k.loadc = 1'b1;
    add(16'hA0A1, 8, 6, k, 16'hFFA1, 16'h0001);
    k = base(16'hA0A1); k.writenum = 3'd5; k.write = 1'b1;
    add(16'hA0A1, 8, 7, k, 16'hFFA1, 16'h0001);
    k = base(16'hA901); k.loads = 1'b1;
    add(16'hA901, 7, 6, k, 16'h0001, 16'h0001);
    k = base(16'hB3D4); k.loadc = 1'b1;
    add(16'hB3D4, 8, 6, k, 16'hFFD4, 16'hFFF4);
    k = base(16'hC06A); k.readnum = 3'd2; k.loadb = 1'b1;
    add(16'hC06A, 7, 4, k, 16'h006A, 16'h000A);
    k = base(16'hC06A); k.asel = 1'b1; k.loadc = 1'b1;
    add(16'hC06A, 7, 5, k, 16'h006A, 16'h000A);
    k = base(16'hB887); k.asel = 1'b1; k.loadc = 1'b1;
    add(16'hB887, 7, 5, k, 16'hFF87, 16'h0007);
    k = base(16'h6241); k.bsel = 1'b1; k.loadc = 1'b1; k.shift = 2'b00; k.aluop = 2'b00;
    add(16'h6241, 9, 5, k, 16'h0041, 16'h0001);
    k = base(16'h6241); k.load_addr = 1'b1;
    add(16'h6241, 9, 6, k, 16'h0041, 16'h0001);
    k = base(16'h6241); k.mem_cmd = 2'b01; k.vsel = 2'b11; k.writenum = 3'd2; k.write = 1'b1;
    add(16'h6241, 9, 8, k, 16'h0041, 16'h0001);
    k = base(16'h6170); k.mem_cmd = 2'b01;
    add(16'h6170, 9, 7, k, 16'h0070, 16'hFFF0);
    k = base(16'h8240); k.bsel = 1'b1; k.loadc = 1'b1; k.shift = 2'b00; k.aluop = 2'b00;
    add(16'h8240, 10, 5, k, 16'h0040, 16'h0000);
    k = base(16'h8240); k.load_addr = 1'b1;
    add(16'h8240, 10, 6, k, 16'h0040, 16'h0000);
    k = base(16'h8240); k.readnum = 3'd2; k.loadb = 1'b1;
    add(16'h8240, 10, 7, k, 16'h0040, 16'h0000);
    k = base(16'h8240); k.asel = 1'b1; k.loadc = 1'b1; k.shift = 2'b00; k.aluop = 2'b00;
    add(16'h8240, 10, 8, k, 16'h0040, 16'h0000);
    k = base(16'h8240); k.mem_cmd = 2'b10;
    add(16'h8240, 10, 9, k, 16'h0040, 16'h0000);

    step(); step();
    chk("reset RST ctrl", cur(), rst_c());
    chk("reset sximm8", sximm8, 16'h0000);
    reset_n = 1'b1;
    step();
    chk("first IF1", cur(), if1_c(16'h0000));

    foreach (tbl[i]) begin
      k = base(tbl[i].instr);
      k.load_pc = 1'b1;
      mem_rdata = tbl[i].instr;
      for (int c = 0; c <= tbl[i].ncyc; c++) begin
        if (c == tbl[i].kidx) chk($sformatf("v%0d %h key c%0d", i, tbl[i].instr, c), cur(), tbl[i].key);
        if (c == 2) chk($sformatf("v%0d UPDATE_PC", i), cur(), k);
        if (c == 3) begin
          chk($sformatf("v%0d sximm8", i), sximm8, tbl[i].sx8);
          chk($sformatf("v%0d sximm5", i), sximm5, tbl[i].sx5);
        end
        if (c == tbl[i].ncyc - 1) chk_ne($sformatf("v%0d early IF1", i), cur(), if1_c(tbl[i].instr));
        if (c == tbl[i].ncyc) chk($sformatf("v%0d back to IF1", i), cur(), if1_c(tbl[i].instr));
        else step();
      end
    end

    mem_rdata = 16'hE000;
    for (int c = 0; c < 4; c++) step();
    k = base(16'hE000);
    k.halt = 1'b1;
    for (int c = 0; c < 20; c++) begin
      chk($sformatf("halt c%0d", c), cur(), k);
      step();
    end

    reset_n = 1'b0;
    #1;
    chk("async reset from HALT", cur(), rst_c());
    step();
    reset_n = 1'b1;
    step();
    chk("IF1 after HALT reset", cur(), if1_c(16'h0000));

    mem_rdata = 16'hA0A1;
    for (int c = 0; c < 6; c++) step();
    k = base(16'hA0A1);
    k.loadc = 1'b1;
    chk("ADD ALU before reset", cur(), k);
    arm = 1'b1;
    reset_n = 1'b0;
    #1;
    chk("async reset mid-ALU ctrl", cur(), rst_c());
    chk("async reset mid-ALU IR", sximm8, 16'h0000);
    step();
    chk("held in RST", cur(), rst_c());
    reset_n = 1'b1;
    step();
    chk("IF1 after mid-ALU reset", cur(), if1_c(16'h0000));
    step();
    step();
    k = base(16'hA0A1);
    k.load_pc = 1'b1;
    chk("refetch UPDATE_PC", cur(), k);
    arm = 1'b0;
    chk("no write after mid-ALU reset", {31'd0, saw_write}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/cpu_controller.md
Name: cpu_controller

Overview:
- Instruction register, decoder and multi-cycle control FSM for the 16-bit CPU.
- Fetches instructions from memory, holds them in an internal IR, and decodes register numbers and sign-extended immediates.
- Drives every control input of the datapath, plus the PC, address-register and memory-command controls, one datapath micro-step per cycle.

Parameters:
- DATA_W, 16, instruction/data word width; the instruction field positions below assume 16.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- mem_rdata  in  DATA_W  memory read data; captured into IR during fetch
- readnum  out  3  regfile read select
- writenum  out  3  regfile write select
- write  out  1  regfile write enable
- vsel  out  2  writeback mux: 11 mdata, 10 sximm8, 01 PC, 00 C
- loada, loadb, loadc, loads  out  1 each  datapath register enables
- asel  out  1  1 forces A operand to 0
- bsel  out  1  1 selects sximm5 for B
- shift  out  2  shifter op
- ALUop  out  2  ALU op
- sximm8  out  DATA_W  sign-extended IR[7:0]
- sximm5  out  DATA_W  sign-extended IR[4:0]
- mem_cmd  out  2  00 none, 01 read, 10 write
- addr_sel  out  1  1 selects PC as memory address, 0 selects address register
- load_pc  out  1  PC register enable
- reset_pc  out  1  with load_pc, PC loads 0 instead of PC+1
- load_addr  out  1  address register enable; loads datapath out[8:0]
- halt  out  1  high in HALT state

Behaviour:
- Instruction fields:
  - opcode = IR[15:13], op = IR[12:11], Rn = IR[10:8], Rd = IR[7:5], sh = IR[4:3], Rm = IR[2:0].
- Reset: reset_n low immediately forces state RST and IR = 0, including mid-instruction. All enables default to 0; mem_cmd = 00, vsel = 00, shift = IR[4:3], ALUop = IR[12:11].
- Outputs are a combinational (Moore) function of state and IR. Every output not listed for a state holds its default.
- Fetch sequence:
  - RST: reset_pc = 1, load_pc = 1 -> IF1.
  - IF1: addr_sel = 1, mem_cmd = 01 -> IF2. Memory has 1-cycle synchronous read latency.
  - IF2: addr_sel = 1, mem_cmd = 01, IR <= mem_rdata at the clock edge -> UPDATE_PC.
  - UPDATE_PC: load_pc = 1 (PC+1) -> DECODE.
- DECODE (no outputs) dispatches on {opcode, op}:
  - 110_10 MOV imm -> WRITE_IMM: writenum = Rn, vsel = 10, write = 1 -> IF1.
  - 110_00 MOV reg -> GET_B.
  - 101_xx ALU ops -> GET_A.
  - 011_00 LDR and 100_00 STR -> GET_A.
  - 111_xx, and any other encoding -> HALT.
- ALU path:
  - GET_A: readnum = Rn, loada = 1 -> GET_B.
  - GET_B: readnum = Rm, loadb = 1 -> ALU.
  - ALU: shift = sh, ALUop = op, loadc = 1, except CMP (101_01), which uses loads = 1 and loadc = 0. MOV reg and MVN also set asel = 1. CMP -> IF1; all others -> WRITE_REG.
  - WRITE_REG: writenum = Rd, vsel = 00, write = 1 -> IF1.
- Load/store path:
  - GET_A: readnum = Rn, loada = 1.
  - ADDR: bsel = 1, ALUop = 00, shift = 00, loadc = 1.
  - LOAD_ADDR: load_addr = 1.
  - LDR then runs MEM_RD (addr_sel = 0, mem_cmd = 01), then LDR_WB (addr_sel = 0, mem_cmd = 01, vsel = 11, writenum = Rd, write = 1) -> IF1.
  - STR then runs STR_B (readnum = Rd, loadb = 1), then STR_C (asel = 1, shift = 00, ALUop = 00, loadc = 1), then MEM_WR (addr_sel = 0, mem_cmd = 10) -> IF1.
- HALT: halt = 1; remains until reset_n is asserted.
- Cycle counts from IF1 back to IF1:
  - MOV imm 5, CMP 7, MOV reg/MVN 7, other ALU ops 8.
  - LDR 9, STR 10.
- No more than one of write, loada, loadb, loadc, loads, load_pc, load_addr is high in any state, except in ALU, where none of the others is high alongside loadc or loads.
- Sign extension: sximm8 = {8{IR[7]}, IR[7:0]}, sximm5 = {11{IR[4]}, IR[4:0]}.

Test Plan:
- Reset then mem_rdata = 16'hD105 (MOV R1,#5) -> RST asserts reset_pc/load_pc. IR = D105 after IF2. WRITE_IMM drives writenum = 1, vsel = 10, sximm8 = 0005, write = 1. Back in IF1 after 5 cycles.
- IR = 16'hD0FF (MOV R0,#-1) -> sximm8 = FFFF. IR = 16'h6241 (LDR R2,[R2,#1]) -> sximm5 = 0001. IR with imm5 = 10000 -> sximm5 = FFF0.
- IR = 16'hA0A1 (ADD R5,R0,R1) -> GET_A readnum = 0; GET_B readnum = 1; ALU ALUop = 00, loadc = 1; WRITE_REG writenum = 5. Total 8 cycles.
- IR = 16'hA901 (CMP R1,R1) -> ALU state has loads = 1 and loadc = 0, no write. IF1 reached after 7 cycles.
- IR = 16'h8240 (STR R2,[R2,#0]) -> ADDR bsel = 1, LOAD_ADDR load_addr = 1, STR_B readnum = 2, STR_C asel = 1, MEM_WR mem_cmd = 10 with addr_sel = 0. IR = 16'hE000 -> halt = 1 held for 20 cycles.
- reset_n pulsed low during the ALU state of an ADD -> state RST and IR = 0 asynchronously, write never asserts, next fetch starts at PC = 0.
